// File: rtl/run_controller.sv
// run_controller - Start/Ack sequencer driving ProgCtr enable/clear and counting RUN cycles.
// Optional watchdog enabled by defining RUN_WATCHDOG_EN.
module run_controller #(
  parameter int CT_W       = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_halt,
  input  logic            i_stall,
  output logic            o_pc_en,
  output logic            o_pc_clr,
  output logic            o_busy,
  output logic            o_ack,
  output logic            o_timeout,
  output logic [CT_W-1:0] o_cycle_ct
);

`ifdef RUN_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  localparam logic [CT_W-1:0] WD_LAST = CT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CT_W-1:0] r_cycle_ct;
  logic            r_timeout;
  logic            w_exit;
  logic            w_wd_fire;
  logic            w_sat;

  // A stalled halt is not yet the final instruction, so it cannot end the run.
  assign w_exit    = i_halt & ~i_stall;
  assign w_wd_fire = WD_EN & (r_cycle_ct == WD_LAST) & ~w_exit;
  assign w_sat     = &r_cycle_ct;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    o_pc_en  = 1'b0;
    o_pc_clr = 1'b0;
    o_busy   = 1'b0;
    o_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_ARM;
      end
      S_ARM: begin
        o_pc_clr = 1'b1;
        if (!i_start) w_next = S_RUN;
      end
      S_RUN: begin
        o_busy  = 1'b1;
        o_pc_en = ~i_stall & ~i_halt;
        if (w_exit || w_wd_fire) w_next = S_DONE;
      end
      S_DONE: begin
        o_ack = 1'b1;
        if (i_start) w_next = S_ARM;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cycle_ct <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_ARM: begin
          r_cycle_ct <= '0;
          r_timeout  <= 1'b0;
        end
        S_RUN: begin
          if (!w_sat) r_cycle_ct <= r_cycle_ct + 1'b1;
          if (w_wd_fire) r_timeout <= 1'b1;
        end
        default: begin
          r_cycle_ct <= r_cycle_ct;
          r_timeout  <= r_timeout;
        end
      endcase
    end
  end

  assign o_timeout  = WD_EN & r_timeout;
  assign o_cycle_ct = r_cycle_ct;

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller - scoreboard bench: directed program sequences plus random Start/Halt/Stall/Reset.
module tb_run_controller;
  localparam int CT_W  = 5;
  localparam int MAX_C = 8;
  localparam int SAT   = (1 << CT_W) - 1;
`ifdef RUN_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            halt = 1'b0;
  logic            stall = 1'b0;
  logic            pc_en, pc_clr, busy, ack, timeout;
  logic [CT_W-1:0] cycle_ct;

  always #5 clk = ~clk;

  run_controller #(.CT_W(CT_W), .MAX_CYCLES(MAX_C)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_start(start),
    .i_halt(halt),
    .i_stall(stall),
    .o_pc_en(pc_en),
    .o_pc_clr(pc_clr),
    .o_busy(busy),
    .o_ack(ack),
    .o_timeout(timeout),
    .o_cycle_ct(cycle_ct)
  );

  logic [CT_W+4:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Program-level model: which phase the program is in, and how long it has run.
  bit m_known = 0, m_armed = 0, m_running = 0, m_finished = 0, m_timeout = 0;
  int m_cycles = 0;

  task automatic step(input bit r, input bit s, input bit h, input bit st);
    bit ex, wd;
    @(posedge clk);
    #1;
    reset = r; start = s; halt = h; stall = st;
    if (m_known)
      exp_q.push_back({m_running & ~st & ~h, m_armed, m_running, m_finished,
                       m_timeout, CT_W'(m_cycles)});
    if (r) begin
      m_armed = 0; m_running = 0; m_finished = 0; m_timeout = 0; m_cycles = 0;
      m_known = 1;
    end else if (m_armed) begin
      m_cycles = 0; m_timeout = 0;
      if (!s) begin m_armed = 0; m_running = 1; end
    end else if (m_running) begin
      ex = h && !st;
      wd = WD && (m_cycles == MAX_C - 1) && !ex;
      if (m_cycles < SAT) m_cycles++;
      if (ex || wd) begin m_running = 0; m_finished = 1; end
      if (wd) m_timeout = 1;
    end else if (m_finished) begin
      if (s) begin m_finished = 0; m_armed = 1; end
    end else if (s) begin
      m_armed = 1;
    end
  endtask

  always @(negedge clk) begin
    logic [CT_W+4:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_en, pc_clr, busy, ack, timeout, cycle_ct};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got pc_en=%b pc_clr=%b busy=%b ack=%b timeout=%b ct=%0d want pc_en=%b pc_clr=%b busy=%b ack=%b timeout=%b ct=%0d",
                 $time, a[CT_W+4], a[CT_W+3], a[CT_W+2], a[CT_W+1], a[CT_W], a[CT_W-1:0],
                 e[CT_W+4], e[CT_W+3], e[CT_W+2], e[CT_W+1], e[CT_W], e[CT_W-1:0]);
      end
    end
  end

  initial begin
    // reset, then idle with Start low
    repeat (2) step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    // Start held 3 cycles, halt on the 10th RUN cycle
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (9) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    // re-arm from DONE; stalled halts must not finish the program
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    // re-arm, one-cycle Start pulse, reset at RUN cycle 5
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // long run to reach counter saturation, Start toggling ignored in RUN
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, i[2], 0, i[0]);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    // watchdog boundary: halt exactly on RUN cycle MAX_C
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (MAX_C - 1) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    // watchdog boundary: no halt at all for a while
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (MAX_C + 4) step(0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 2,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
